// File: rtl/mul_if.sv
// Execute/Memory handshake between the pipeline and the iterative multiplier.
// The pipeline drives the master side; the multiplier implements the slave side.
interface mul_if #(
    parameter int unsigned XLEN = 64
);
    logic            StallM;
    logic            FlushE;
    logic            IntMulE;
    logic [1:0]      MulOpE;
    logic            W64E;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            MulBusyE;
    logic [XLEN-1:0] ProdM;

    modport master (
        output StallM, FlushE, IntMulE, MulOpE, W64E, SrcAE, SrcBE,
        input  MulBusyE, ProdM
    );

    modport slave (
        input  StallM, FlushE, IntMulE, MulOpE, W64E, SrcAE, SrcBE,
        output MulBusyE, ProdM
    );
endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier (MUL/MULH/MULHSU/MULHU/MULW), BITSPERCYCLE bits per cycle.
// Optional MUL_EARLY_OUT_EN: finish once the unconsumed multiplier bits are all zero.
module mul_iter #(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned BITSPERCYCLE = 1
) (
    input  logic clk,
    input  logic reset,
    mul_if.slave bus
);
    localparam int unsigned N_FULL = XLEN / BITSPERCYCLE;
    localparam int unsigned N_W    = 32 / BITSPERCYCLE;
    localparam int unsigned CNT_W  = $clog2(N_FULL + 1);
    localparam int unsigned PW     = 2 * XLEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            mul_start;
    logic            last_step;

    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [1:0]      op_m;
    logic            neg_m;
    logic            w64_m;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] n_sel;

    logic            w64_in;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] a_abs_in;
    logic [XLEN-1:0] b_abs_in;

    logic [XLEN-1:0] hi_step;
    logic [XLEN-1:0] lo_step;
    logic [XLEN:0]   sum;
    logic [PW-1:0]   prod_next;

    logic [PW-1:0]   prod_signed;
    logic [XLEN-1:0] prod_c;

    // Operand conditioning: signs only matter for the high-half ops
    assign w64_in = (XLEN > 32) && bus.W64E;

    always_comb begin
        sign_a   = bus.SrcAE[XLEN-1] & ((bus.MulOpE == 2'b01) | (bus.MulOpE == 2'b10)) & ~w64_in;
        sign_b   = bus.SrcBE[XLEN-1] & (bus.MulOpE == 2'b01) & ~w64_in;
        a_abs_in = sign_a ? -bus.SrcAE : bus.SrcAE;
        b_abs_in = sign_b ? -bus.SrcBE : bus.SrcBE;
        if (w64_in) begin
            a_abs_in = XLEN'(bus.SrcAE[31:0]);
            b_abs_in = XLEN'(bus.SrcBE[31:0]);
        end
    end

    // BITSPERCYCLE shift-add steps per cycle; carry-out shifts into Hi
    always_comb begin
        hi_step = hi;
        lo_step = lo;
        sum     = '0;
        for (int i = 0; i < int'(BITSPERCYCLE); i++) begin
            sum                = {1'b0, hi_step} + (lo_step[0] ? {1'b0, a_abs} : (XLEN+1)'(0));
            {hi_step, lo_step} = {sum, lo_step[XLEN-1:1]};
        end
    end

    assign n_sel    = w64_m ? CNT_W'(N_W) : CNT_W'(N_FULL);
    assign cnt_next = cnt + CNT_W'(1);

`ifdef MUL_EARLY_OUT_EN
    localparam int unsigned SH_W = $clog2(XLEN + 1);

    logic [CNT_W-1:0] rem_steps;
    logic [SH_W-1:0]  rem_bits;
    logic [XLEN-1:0]  rem_mask;
    logic             rem_zero;

    // Remaining multiplier bits sit at the bottom of Lo; skipping them is a pure shift
    always_comb begin
        rem_steps = n_sel - cnt_next;
        rem_bits  = SH_W'(rem_steps) * SH_W'(BITSPERCYCLE);
        rem_mask  = ~({XLEN{1'b1}} << rem_bits);
        rem_zero  = ~|(lo_step & rem_mask);
        last_step = (cnt_next == n_sel) | rem_zero;
        prod_next = {hi_step, lo_step};
        if (last_step) begin
            prod_next = {hi_step, lo_step} >> rem_bits;
        end
    end
`else
    always_comb begin
        last_step = (cnt_next == n_sel);
        prod_next = {hi_step, lo_step};
    end
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; flush aborts from any state
    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.IntMulE && !bus.StallM) begin
                    mul_start  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!bus.StallM) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (bus.FlushE) begin
            state_next = IDLE;
        end
    end

    assign bus.MulBusyE = (state == BUSY) | mul_start;

    // Datapath and Memory-stage operation flops
    always_ff @(posedge clk) begin
        if (reset) begin
            a_abs <= '0;
            hi    <= '0;
            lo    <= '0;
            op_m  <= '0;
            neg_m <= 1'b0;
            w64_m <= 1'b0;
            cnt   <= '0;
        end else if (mul_start) begin
            a_abs <= a_abs_in;
            hi    <= '0;
            lo    <= b_abs_in;
            op_m  <= bus.MulOpE;
            neg_m <= sign_a ^ sign_b;
            w64_m <= w64_in;
            cnt   <= '0;
        end else if (state == BUSY) begin
            {hi, lo} <= prod_next;
            cnt      <= cnt_next;
        end
    end

    // Result select; held registers keep ProdM stable through a stalled DONE
    always_comb begin
        prod_signed = neg_m ? -{hi, lo} : {hi, lo};
        if (w64_m) begin
            prod_c = XLEN'($signed(lo[XLEN-1:XLEN-32]));
        end else if (op_m == 2'b00) begin
            prod_c = prod_signed[XLEN-1:0];
        end else begin
            prod_c = prod_signed[PW-1:XLEN];
        end
    end

    assign bus.ProdM = prod_c;
endmodule
